// File: rtl/pixel_coord_gen_pkg.sv
// Shared types and helpers for the pixel coordinate generator.
package pixel_coord_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pcg_state_t;

  // $clog2 of 1 is 0; a port still needs at least one bit.
  function automatic int unsigned clog2_min1(input int unsigned value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/pixel_coord_gen_wrap_counter.sv
// Counter from 0 to MAX_VAL that wraps back to 0 when incremented at MAX_VAL.
module wrap_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MAX_VAL = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  logic [WIDTH-1:0] count_q, count_d;

  assign at_max = (count_q == WIDTH'(MAX_VAL));
  assign count  = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = at_max ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pixel_coord_gen.sv
// Walks a frame in row-major order, one (x, y) per ready/valid transfer.
module pixel_coord_gen
  import pixel_coord_gen_pkg::*;
#(
  parameter int unsigned IMG_W   = 64,
  parameter int unsigned IMG_H   = 48,
  parameter int unsigned X_WIDTH = clog2_min1(IMG_W),
  parameter int unsigned Y_WIDTH = clog2_min1(IMG_H)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [X_WIDTH-1:0] out_x,
  output logic [Y_WIDTH-1:0] out_y,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  pcg_state_t state_q, state_d;
  logic valid_q, valid_d;
  logic last_q, last_d;
  logic xfer, cnt_clr;
  logic [X_WIDTH-1:0] x_cnt, x_next;
  logic [Y_WIDTH-1:0] y_cnt, y_next;
  logic x_at_max, y_at_max;

  // valid_q is only ever set in RUN, so a transfer implies RUN.
  assign xfer    = valid_q && out_ready;
  assign cnt_clr = (state_q == IDLE);

  wrap_counter #(
    .WIDTH   (X_WIDTH),
    .MAX_VAL (IMG_W - 1)
  ) u_x_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (xfer),
    .clr    (cnt_clr),
    .count  (x_cnt),
    .at_max (x_at_max)
  );

  wrap_counter #(
    .WIDTH   (Y_WIDTH),
    .MAX_VAL (IMG_H - 1)
  ) u_y_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (xfer && x_at_max),
    .clr    (cnt_clr),
    .count  (y_cnt),
    .at_max (y_at_max)
  );

  always_comb begin
    // Mirrors the counters' next value so out_last can be registered alongside them.
    x_next = x_at_max ? '0 : x_cnt + X_WIDTH'(1);
    if (!x_at_max) begin
      y_next = y_cnt;
    end else begin
      y_next = y_at_max ? '0 : y_cnt + Y_WIDTH'(1);
    end

    state_d = state_q;
    valid_d = valid_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          state_d = RUN;
          valid_d = 1'b1;
          last_d  = (IMG_W == 1) && (IMG_H == 1);
        end
      end
      RUN: begin
        if (xfer) begin
          if (last_q) begin
            state_d = DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            last_d = (x_next == X_WIDTH'(IMG_W - 1)) && (y_next == Y_WIDTH'(IMG_H - 1));
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_x     = x_cnt;
  assign out_y     = y_cnt;
  assign out_last  = last_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_pixel_coord_gen.sv
// Directed bench for pixel_coord_gen in 3x2, 1x1 and 4x1 configurations.
module tb_pixel_coord_gen;

  logic clk;
  logic rst_n;

  logic       go0, rdy0, v0, l0, b0, dn0;
  logic [1:0] x0;
  logic [0:0] y0;

  logic       go1, rdy1, v1, l1, b1, dn1;
  logic [0:0] x1;
  logic [0:0] y1;

  logic       go2, rdy2, v2, l2, b2, dn2;
  logic [1:0] x2;
  logic [0:0] y2;

  int n_assert;
  int n_fail;

  pixel_coord_gen #(.IMG_W(3), .IMG_H(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .go(go0), .out_ready(rdy0), .out_valid(v0),
    .out_x(x0), .out_y(y0), .out_last(l0), .busy(b0), .done(dn0)
  );

  pixel_coord_gen #(.IMG_W(1), .IMG_H(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .go(go1), .out_ready(rdy1), .out_valid(v1),
    .out_x(x1), .out_y(y1), .out_last(l1), .busy(b1), .done(dn1)
  );

  pixel_coord_gen #(.IMG_W(4), .IMG_H(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .go(go2), .out_ready(rdy2), .out_valid(v2),
    .out_x(x2), .out_y(y2), .out_last(l2), .busy(b2), .done(dn2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Checks a full beat on the 3x2 instance.
  task automatic beat0(input string tag, input int ex, input int ey, input int el);
    chk({tag, ".valid"}, 32'(v0), 1);
    chk({tag, ".x"}, 32'(x0), ex);
    chk({tag, ".y"}, 32'(y0), ey);
    chk({tag, ".last"}, 32'(l0), el);
  endtask

  int exp_x[6] = '{0, 1, 2, 0, 1, 2};
  int exp_y[6] = '{0, 0, 0, 1, 1, 1};

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    {go0, rdy0, go1, rdy1, go2, rdy2} = '0;
    step();
    step();
    chk("rst.valid", 32'(v0), 0);
    chk("rst.x", 32'(x0), 0);
    chk("rst.y", 32'(y0), 0);
    chk("rst.last", 32'(l0), 0);
    chk("rst.busy", 32'(b0), 0);
    chk("rst.done", 32'(dn0), 0);
    rst_n = 1'b1;

    // Full-throughput frame.
    go0 = 1'b1;
    step();
    go0  = 1'b0;
    rdy0 = 1'b1;
    chk("t1.busy", 32'(b0), 1);
    for (int k = 0; k < 6; k++) begin
      beat0($sformatf("t1.beat%0d", k), exp_x[k], exp_y[k], (k == 5) ? 1 : 0);
      chk($sformatf("t1.done%0d", k), 32'(dn0), 0);
      step();
    end
    chk("t1.end.done", 32'(dn0), 1);
    chk("t1.end.valid", 32'(v0), 0);
    chk("t1.end.busy", 32'(b0), 1);
    rdy0 = 1'b0;
    step();
    chk("t1.idle.done", 32'(dn0), 0);
    chk("t1.idle.busy", 32'(b0), 0);

    // Stalled frame: each beat held for two cycles with ready low.
    go0 = 1'b1;
    step();
    go0 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      beat0($sformatf("t2.beat%0d", k), exp_x[k], exp_y[k], (k == 5) ? 1 : 0);
      step();
      beat0($sformatf("t2.hold%0d", k), exp_x[k], exp_y[k], (k == 5) ? 1 : 0);
      rdy0 = 1'b1;
      step();
      rdy0 = 1'b0;
    end
    chk("t2.end.done", 32'(dn0), 1);
    chk("t2.end.valid", 32'(v0), 0);
    step();
    chk("t2.idle.done", 32'(dn0), 0);
    chk("t2.idle.busy", 32'(b0), 0);

    // go re-pulsed during RUN is ignored.
    go0 = 1'b1;
    step();
    go0  = 1'b0;
    rdy0 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      beat0($sformatf("t3.beat%0d", k), exp_x[k], exp_y[k], (k == 5) ? 1 : 0);
      go0 = (k == 2);
      step();
    end
    go0 = 1'b0;
    chk("t3.end.done", 32'(dn0), 1);
    rdy0 = 1'b0;
    step();
    chk("t3.idle.done", 32'(dn0), 0);
    chk("t3.idle.busy", 32'(b0), 0);
    chk("t3.idle.valid", 32'(v0), 0);
    step();
    chk("t3.idle2.busy", 32'(b0), 0);

    // Asynchronous reset mid-frame.
    go0 = 1'b1;
    step();
    go0  = 1'b0;
    rdy0 = 1'b1;
    for (int k = 0; k < 3; k++) step();
    beat0("t4.beat3", 0, 1, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t4.rst.valid", 32'(v0), 0);
    chk("t4.rst.x", 32'(x0), 0);
    chk("t4.rst.y", 32'(y0), 0);
    chk("t4.rst.busy", 32'(b0), 0);
    step();
    chk("t4.rst.done", 32'(dn0), 0);
    rst_n = 1'b1;
    rdy0  = 1'b0;
    step();
    chk("t4.post.done", 32'(dn0), 0);
    go0 = 1'b1;
    step();
    go0 = 1'b0;
    beat0("t4.restart", 0, 0, 0);

    // 1x1 frame with go held high.
    go1  = 1'b1;
    rdy1 = 1'b1;
    for (int f = 0; f < 2; f++) begin
      step();
      chk($sformatf("t5.f%0d.valid", f), 32'(v1), 1);
      chk($sformatf("t5.f%0d.last", f), 32'(l1), 1);
      chk($sformatf("t5.f%0d.xy", f), 32'({x1, y1}), 0);
      chk($sformatf("t5.f%0d.busy", f), 32'(b1), 1);
      step();
      chk($sformatf("t5.f%0d.done", f), 32'(dn1), 1);
      chk($sformatf("t5.f%0d.dvalid", f), 32'(v1), 0);
      if (f == 1) go1 = 1'b0;
      step();
      chk($sformatf("t5.f%0d.idone", f), 32'(dn1), 0);
      chk($sformatf("t5.f%0d.ibusy", f), 32'(b1), 0);
    end
    step();
    chk("t5.stop.busy", 32'(b1), 0);

    // 4x1 frame with a long initial stall.
    go2 = 1'b1;
    step();
    go2 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t6.stall%0d.valid", i), 32'(v2), 1);
      chk($sformatf("t6.stall%0d.x", i), 32'(x2), 0);
      chk($sformatf("t6.stall%0d.done", i), 32'(dn2), 0);
      step();
    end
    chk("t6.y", 32'(y2), 0);
    chk("t6.last0", 32'(l2), 0);
    rdy2 = 1'b1;
    for (int k = 1; k < 4; k++) begin
      step();
      chk($sformatf("t6.beat%0d.x", k), 32'(x2), k);
      chk($sformatf("t6.beat%0d.y", k), 32'(y2), 0);
      chk($sformatf("t6.beat%0d.last", k), 32'(l2), (k == 3) ? 1 : 0);
    end
    step();
    chk("t6.done", 32'(dn2), 1);
    chk("t6.end.valid", 32'(v2), 0);
    step();
    chk("t6.idle.busy", 32'(b2), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
